// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control-code constants and execution FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // 3-bit ALU control codes produced by the ALU decoder
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Execution unit FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative shift-add multiplier, one partial product per cycle,
//               low WIDTH bits of the product kept.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_product
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  // Latch operands on start, then run exactly WIDTH shift-add steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == c_LAST) begin
        r_run <= 1'b0;
      end
    end
  end

  // High in the cycle whose closing edge performs the final step
  assign o_last    = r_run && (r_cnt == c_LAST);
  assign o_product = r_acc;

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : ALU execution unit with valid/ready handshake. Single-cycle
//               add/sub/and/or/slt and an iterative multi-cycle MUL.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  exec_state_t      r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_busy;

  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_alu;

  assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (alu_control == ALU_MUL);

  // Single-cycle datapath; reserved codes yield zero
  always_comb begin
    w_alu = '0;
    case (alu_control)
      ALU_ADD: w_alu = src_a + src_b;
      ALU_SUB: w_alu = src_a - src_b;
      ALU_AND: w_alu = src_a & src_b;
      ALU_OR:  w_alu = src_a | src_b;
      ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: w_alu = '0;
    endcase
  end

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (src_a),
    .i_b       (src_b),
    .o_last    (w_mul_last),
    .o_product (w_mul_product)
  );

  // Control FSM plus registered result/zero/valid/busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (alu_control == ALU_MUL) begin
              // Output register is empty or being popped this edge
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= ST_MUL;
            end else begin
              r_result    <= w_alu;
              r_zero      <= (w_alu == '0);
              r_out_valid <= 1'b1;
            end
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (w_mul_last) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_result    <= w_mul_product;
          r_zero      <= (w_mul_product == '0);
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign busy      = r_busy;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    alu_control = c;
    src_a       = a;
    src_b       = b;
  endtask

  int n_busy;
  int k_valid;
  int ready_bad;
  int stale;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 3'b000; src_a = '0; src_b = '0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // add 5+7
    out_ready = 1'b1;
    drive(3'b000, 32'd5, 32'd7);
    step();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", result, 32'd12);
    chk("add_zero", {31'd0, zero}, 32'd0);

    // sub to zero, then wrap
    drive(3'b001, 32'd9, 32'd9);
    step();
    chk("sub_zero_result", result, 32'd0);
    chk("sub_zero_flag", {31'd0, zero}, 32'd1);
    drive(3'b001, 32'd0, 32'd1);
    step();
    chk("sub_wrap", result, 32'hFFFF_FFFF);
    chk("sub_wrap_zero", {31'd0, zero}, 32'd0);

    // signed less-than
    drive(3'b101, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("slt_neg_lt_pos", result, 32'd1);
    drive(3'b101, 32'd1, 32'hFFFF_FFFF);
    step();
    chk("slt_pos_lt_neg", result, 32'd0);
    chk("slt_zero_flag", {31'd0, zero}, 32'd1);

    // reserved code gives zero
    drive(3'b111, 32'h1234, 32'h5678);
    step();
    chk("rsvd_result", result, 32'd0);
    chk("rsvd_zero", {31'd0, zero}, 32'd1);

    // and accepted, then backpressure holds it
    drive(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    out_ready = 1'b0;
    chk("and_result", result, 32'h0000_F000);
    drive(3'b011, 32'h1, 32'h2);
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_hold_result", result, 32'h0000_F000);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);

    // pop and accept in the same cycle
    out_ready = 1'b1;
    #1;
    chk("pop_accept_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("or_result", result, 32'd3);
    chk("or_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("pop_only_valid", {31'd0, out_valid}, 32'd0);

    // MUL 123*1000, inputs disturbed while busy
    drive(3'b100, 32'd123, 32'd1000);
    step();
    drive(3'b000, 32'd1, 32'd1);
    n_busy = 0; k_valid = 0; ready_bad = 0;
    if (busy) n_busy++;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (busy) begin
        n_busy++;
        if (in_ready) ready_bad++;
      end
      if (out_valid && k_valid == 0) begin
        k_valid = k;
        break;
      end
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", n_busy, 32'd32);
    chk("mul_ready_while_busy", ready_bad, 32'd0);
    chk("mul_latency", k_valid, 32'd33);
    chk("mul_result", result, 32'd123000);
    chk("mul_zero", {31'd0, zero}, 32'd0);

    // MUL overflow to zero
    drive(3'b100, 32'h0001_0000, 32'h0001_0000);
    step();
    in_valid = 1'b0;
    k_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (out_valid) begin
        k_valid = k;
        break;
      end
    end
    chk("mul_ovf_latency", k_valid, 32'd33);
    chk("mul_ovf_result", result, 32'd0);
    chk("mul_ovf_zero", {31'd0, zero}, 32'd1);

    // reset during MUL
    step();
    drive(3'b100, 32'd7, 32'd9);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_zero", {31'd0, zero}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid || busy) stale++;
    end
    chk("post_rst_no_stale", stale, 32'd0);
    drive(3'b000, 32'd2, 32'd2);
    step();
    in_valid = 1'b0;
    chk("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_add", result, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_exec_unit
`default_nettype wire
